univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 4: register width in bits; legal range 2..32.
REQ-002 Parameter RST_VAL, default 0: value loaded into q on reset (WIDTH bits).
REQ-003 Localparam CW = clog2(WIDTH+1): shift-counter width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  clock enable; when low, all state holds.
REQ-007 mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-008 d  input  WIDTH  parallel load data.
REQ-009 sin_r  input  1  serial input, enters the MSB on a shift right.
REQ-010 sin_l  input  1  serial input, enters the LSB on a shift left.
REQ-011 q  output  WIDTH  register contents (parallel out).
REQ-012 sout_r  output  1  serial output for right shifts, equal to q[0].
REQ-013 sout_l  output  1  serial output for left shifts, equal to q[WIDTH-1].
REQ-014 shift_cnt  output  CW  number of shifts since the last load, reset or frame completion.
REQ-015 frame_done  output  1  registered one-cycle pulse when a WIDTH-shift frame completes.

Function
REQ-016 en=1, mode=11: q <= d, shift_cnt <= 0 and frame_done <= 0 on the next edge; latency 1 cycle.
REQ-017 en=1, mode=01: q <= {sin_r, q[WIDTH-1:1]} on the next edge.
REQ-018 en=1, mode=10: q <= {q[WIDTH-2:0], sin_l} on the next edge.
REQ-019 en=1, mode=00: q and shift_cnt hold; frame_done <= 0.
REQ-020 en=0: q and shift_cnt hold regardless of mode; frame_done <= 0.
REQ-021 Every enabled shift in either direction increments shift_cnt by 1.
REQ-022 On the edge performing the WIDTH-th shift of a frame: shift_cnt wraps to 0 and frame_done <= 1 for exactly one cycle.
REQ-023 Consecutive frames produce frame_done pulses every WIDTH enabled shift cycles, with no dead cycle.
REQ-024 A direction change mid-frame does not reset shift_cnt; left and right shifts count alike.
REQ-025 A load mid-frame aborts the frame: shift_cnt returns to 0 and no frame_done is generated.
REQ-026 sout_r and sout_l are combinational taps of q with no extra latency.
REQ-027 A hold or en=0 cycle mid-frame pauses the frame; counting resumes on the next shift.
REQ-028 frame_done never remains high for two consecutive cycles.

Reset
REQ-029 rst=1 forces, asynchronously and without waiting for clk: q=RST_VAL, shift_cnt=0, frame_done=0.
REQ-030 While rst=1, all inputs are ignored; the first edge after deassertion performs normal operation.
REQ-031 Reset asserted mid-frame discards the partial frame; no frame_done follows.

Verification (WIDTH=4, RST_VAL=0)
REQ-032 Reset, then rst=0, en=1, mode=11, d=1011 -> q=1011 after one edge; shift_cnt=0.
REQ-033 From q=1011: mode=01, sin_r=0 for 4 edges.
- q goes 0101, 0010, 0001, 0000.
- sout_r before each edge is 1, 1, 0, 1.
- frame_done is high only in the cycle after the 4th edge; shift_cnt returns to 0.
REQ-034 From q=0000: mode=10, sin_l=1 for 4 edges.
- q goes 0001, 0011, 0111, 1111.
- sout_l=1 after the 4th edge; frame_done pulses once.
REQ-035 Mid-frame events:
- After 2 right shifts, an en=0 cycle with mode=11, d=0110: q and shift_cnt=2 unchanged.
- Then 2 more shifts: frame_done pulses.
- Repeat with a load after 2 shifts: no frame_done, shift_cnt=0.
REQ-036 Assert rst between clock edges after 3 shifts -> q=0000 and shift_cnt=0 immediately; frame_done stays 0 after release.
REQ-037 8 continuous right shifts after a load -> frame_done high in exactly 2 cycles, 4 cycles apart.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left or parallel load, with a WIDTH-shift frame counter.
// Latency 1 cycle for every operation; no backpressure, en=0 freezes all state.
module univ_shift_reg #(
  parameter int                 WIDTH   = 4,
  parameter logic [WIDTH-1:0]   RST_VAL = '0,
  localparam int                CW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    shift_cnt,
  output logic             frame_done
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             done_nxt;
  logic             shifting;

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

  always_comb begin
    q_nxt    = q;
    cnt_nxt  = shift_cnt;
    done_nxt = 1'b0;
    shifting = 1'b0;
    if (en) begin
      case (mode)
        MODE_RIGHT: begin
          q_nxt    = {sin_r, q[WIDTH-1:1]};
          shifting = 1'b1;
        end
        MODE_LEFT: begin
          q_nxt    = {q[WIDTH-2:0], sin_l};
          shifting = 1'b1;
        end
        MODE_LOAD: begin
          q_nxt   = d;
          cnt_nxt = '0;
        end
        MODE_HOLD: begin
          q_nxt = q;
        end
        default: begin
          q_nxt = q;
        end
      endcase
    end
    // The WIDTH-th shift wraps the counter and starts the next frame immediately.
    if (shifting) begin
      if (shift_cnt == LAST_CNT) begin
        cnt_nxt  = '0;
        done_nxt = 1'b1;
      end else begin
        cnt_nxt = shift_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q          <= RST_VAL;
      shift_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      q          <= q_nxt;
      shift_cnt  <= cnt_nxt;
      frame_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed table-driven bench for univ_shift_reg at WIDTH=4, RST_VAL=0.
module tb_univ_shift_reg;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] d;
  logic       sin_r;
  logic       sin_l;
  logic [3:0] q;
  logic       sout_r;
  logic       sout_l;
  logic [2:0] shift_cnt;
  logic       frame_done;

  int total = 0;
  int bad   = 0;

  univ_shift_reg #(.WIDTH(4), .RST_VAL(4'b0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .d          (d),
    .sin_r      (sin_r),
    .sin_l      (sin_l),
    .q          (q),
    .sout_r     (sout_r),
    .sout_l     (sout_l),
    .shift_cnt  (shift_cnt),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [3:0] d;
    logic       sr;
    logic       sl;
    logic [3:0] eq;
    logic [2:0] ec;
    logic       ef;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic e, input logic [1:0] m, input logic [3:0] dd,
                     input logic sr, input logic sl,
                     input logic [3:0] eq, input logic [2:0] ec, input logic ef);
    vec_t v;
    v.en = e; v.mode = m; v.d = dd; v.sr = sr; v.sl = sl;
    v.eq = eq; v.ec = ec; v.ef = ef;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] eq, input logic [2:0] ec, input logic ef);
    check({tag, "_q"},    32'(q),          32'(eq));
    check({tag, "_cnt"},  32'(shift_cnt),  32'(ec));
    check({tag, "_done"}, 32'(frame_done), 32'(ef));
    check({tag, "_sr"},   32'(sout_r),     32'(eq[0]));
    check({tag, "_sl"},   32'(sout_l),     32'(eq[3]));
  endtask

  task automatic drive(input logic e, input logic [1:0] m, input logic [3:0] dd,
                       input logic sr, input logic sl);
    en = e; mode = m; d = dd; sin_r = sr; sin_l = sl;
  endtask

  // Inputs change on the falling edge; results are sampled on the following falling edge.
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //  en mode   d       sr   sl   q        cnt  done
    // load then one right-shift frame with sin_r=0
    add(1, 2'b11, 4'b1011, 0, 0, 4'b1011, 3'd0, 0);
    add(1, 2'b01, 4'b0000, 0, 0, 4'b0101, 3'd1, 0);
    add(1, 2'b01, 4'b0000, 0, 0, 4'b0010, 3'd2, 0);
    add(1, 2'b01, 4'b0000, 0, 0, 4'b0001, 3'd3, 0);
    add(1, 2'b01, 4'b0000, 0, 0, 4'b0000, 3'd0, 1);
    // left-shift frame with sin_l=1
    add(1, 2'b10, 4'b0000, 0, 1, 4'b0001, 3'd1, 0);
    add(1, 2'b10, 4'b0000, 0, 1, 4'b0011, 3'd2, 0);
    add(1, 2'b10, 4'b0000, 0, 1, 4'b0111, 3'd3, 0);
    add(1, 2'b10, 4'b0000, 0, 1, 4'b1111, 3'd0, 1);
    add(1, 2'b00, 4'b0000, 0, 0, 4'b1111, 3'd0, 0);
    // pause mid-frame (en=0 with load, then hold), direction change, completion
    add(1, 2'b11, 4'b0001, 0, 0, 4'b0001, 3'd0, 0);
    add(1, 2'b01, 4'b0000, 1, 0, 4'b1000, 3'd1, 0);
    add(1, 2'b01, 4'b0000, 0, 0, 4'b0100, 3'd2, 0);
    add(0, 2'b11, 4'b0110, 0, 0, 4'b0100, 3'd2, 0);
    add(1, 2'b00, 4'b0110, 0, 0, 4'b0100, 3'd2, 0);
    add(1, 2'b10, 4'b0000, 0, 0, 4'b1000, 3'd3, 0);
    add(1, 2'b01, 4'b0000, 1, 0, 4'b1100, 3'd0, 1);
    // load mid-frame aborts the frame
    add(1, 2'b01, 4'b0000, 0, 0, 4'b0110, 3'd1, 0);
    add(1, 2'b10, 4'b0000, 0, 1, 4'b1101, 3'd2, 0);
    add(1, 2'b11, 4'b1010, 0, 0, 4'b1010, 3'd0, 0);
    add(1, 2'b01, 4'b0000, 0, 0, 4'b0101, 3'd1, 0);
    add(1, 2'b01, 4'b0000, 0, 0, 4'b0010, 3'd2, 0);
    add(1, 2'b01, 4'b0000, 0, 0, 4'b0001, 3'd3, 0);
    add(1, 2'b01, 4'b0000, 0, 0, 4'b0000, 3'd0, 1);
    // 8 back-to-back right shifts: two pulses four cycles apart
    add(1, 2'b11, 4'b1011, 0, 0, 4'b1011, 3'd0, 0);
    add(1, 2'b01, 4'b0000, 1, 0, 4'b1101, 3'd1, 0);
    add(1, 2'b01, 4'b0000, 0, 0, 4'b0110, 3'd2, 0);
    add(1, 2'b01, 4'b0000, 1, 0, 4'b1011, 3'd3, 0);
    add(1, 2'b01, 4'b0000, 1, 0, 4'b1101, 3'd0, 1);
    add(1, 2'b01, 4'b0000, 0, 0, 4'b0110, 3'd1, 0);
    add(1, 2'b01, 4'b0000, 0, 0, 4'b0011, 3'd2, 0);
    add(1, 2'b01, 4'b0000, 1, 0, 4'b1001, 3'd3, 0);
    add(1, 2'b01, 4'b0000, 0, 0, 4'b0100, 3'd0, 1);
    add(1, 2'b00, 4'b0000, 0, 0, 4'b0100, 3'd0, 0);
    add(0, 2'b10, 4'b0000, 0, 1, 4'b0100, 3'd0, 0);

    // reset state
    rst = 1'b1;
    drive(1, 2'b11, 4'b1010, 1, 1);
    #2;
    check_all("rst_async", 4'b0000, 3'd0, 1'b0);
    step();
    check_all("rst_ignore_inputs", 4'b0000, 3'd0, 1'b0);
    #2 rst = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].en, vq[i].mode, vq[i].d, vq[i].sr, vq[i].sl);
      step();
      check_all($sformatf("vec%0d", i), vq[i].eq, vq[i].ec, vq[i].ef);
    end

    // reset asserted between edges after 3 shifts discards the frame
    drive(1, 2'b11, 4'b1111, 0, 0);
    step();
    drive(1, 2'b01, 4'b0000, 1, 0);
    step();
    step();
    step();
    check_all("pre_rst", 4'b1111, 3'd3, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_all("mid_rst", 4'b0000, 3'd0, 1'b0);
    drive(1, 2'b00, 4'b0000, 0, 0);
    #1 rst = 1'b0;
    step();
    check_all("post_rst_hold0", 4'b0000, 3'd0, 1'b0);
    step();
    check_all("post_rst_hold1", 4'b0000, 3'd0, 1'b0);
    drive(1, 2'b10, 4'b0000, 0, 1);
    step();
    check_all("post_rst_shift", 4'b0001, 3'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
